// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encoding.
package shift_pkg;

    typedef logic [1:0] shift_mode_t;

    localparam shift_mode_t MODE_SLL = 2'b00;
    localparam shift_mode_t MODE_SRL = 2'b01;
    localparam shift_mode_t MODE_SRA = 2'b10;
    localparam shift_mode_t MODE_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by 2^K followed by its pipeline register.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5,
    parameter int K       = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               advance,
    input  logic               src_valid,
    input  logic [WIDTH-1:0]   src_data,
    input  logic [SHAMT_W-1:0] src_shamt,
    input  shift_mode_t        src_mode,
    input  logic               src_sign,
    input  logic [TAG_W-1:0]   src_tag,
    output logic               valid,
    output logic [WIDTH-1:0]   data,
    output logic [SHAMT_W-1:0] shamt,
    output shift_mode_t        mode,
    output logic               sign,
    output logic [TAG_W-1:0]   tag
);

    localparam int SH = 2 ** K;

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input shift_mode_t      m,
        input logic             s
    );
        logic [WIDTH-1:0] fill;
        // SRA uses the sign captured at entry, since earlier stages may not have shifted yet.
        fill = s ? ~({WIDTH{1'b1}} >> SH) : '0;
        case (m)
            MODE_SLL: shift_step = d << SH;
            MODE_SRL: shift_step = d >> SH;
            MODE_SRA: shift_step = (d >> SH) | fill;
            default:  shift_step = (d >> SH) | (d << (WIDTH - SH));
        endcase
    endfunction

    logic [WIDTH-1:0] data_next;

    assign data_next = src_shamt[K] ? shift_step(src_data, src_mode, src_sign) : src_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            mode  <= MODE_SLL;
            sign  <= 1'b0;
            tag   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= src_valid;
            data  <= data_next;
            shamt <= src_shamt;
            mode  <= src_mode;
            sign  <= src_sign;
            tag   <= src_tag;
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one log2 stage per register, global-stall handshake.
module pipelined_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  shift_mode_t        in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [SHAMT_W:0]   inflight
);

    localparam int STAGES = SHAMT_W;

    logic               stage_valid [0:STAGES];
    logic [WIDTH-1:0]   stage_data  [0:STAGES];
    logic [SHAMT_W-1:0] stage_shamt [0:STAGES];
    shift_mode_t        stage_mode  [0:STAGES];
    logic               stage_sign  [0:STAGES];
    logic [TAG_W-1:0]   stage_tag   [0:STAGES];

    logic advance;
    logic accept;
    logic retire;
    logic [SHAMT_W:0] count;
    logic unused_tail;

    // Whole pipe moves together; only a held result at the output can stall it.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & in_ready & ~flush;
    assign retire   = out_valid & out_ready & ~flush;

    assign stage_valid[0] = in_valid & in_ready;
    assign stage_data[0]  = in_data;
    assign stage_shamt[0] = in_shamt;
    assign stage_mode[0]  = in_mode;
    assign stage_sign[0]  = in_data[WIDTH-1];
    assign stage_tag[0]   = in_tag;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shift_stage #(
            .WIDTH  (WIDTH),
            .SHAMT_W(SHAMT_W),
            .TAG_W  (TAG_W),
            .K      (k)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush),
            .advance  (advance),
            .src_valid(stage_valid[k]),
            .src_data (stage_data[k]),
            .src_shamt(stage_shamt[k]),
            .src_mode (stage_mode[k]),
            .src_sign (stage_sign[k]),
            .src_tag  (stage_tag[k]),
            .valid    (stage_valid[k+1]),
            .data     (stage_data[k+1]),
            .shamt    (stage_shamt[k+1]),
            .mode     (stage_mode[k+1]),
            .sign     (stage_sign[k+1]),
            .tag      (stage_tag[k+1])
        );
    end

    assign out_valid = stage_valid[STAGES];
    assign out_data  = stage_data[STAGES];
    assign out_tag   = stage_tag[STAGES];
    assign inflight  = count;

    assign unused_tail = ^{stage_shamt[STAGES], stage_mode[STAGES], stage_sign[STAGES]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed vectors, stall/flush/reset sequences, random traffic.
module tb_pipelined_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [5:0]  inflight;

    pipelined_shifter #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) dut (
        .clock    (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .inflight (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [1:0]  mode;
        logic [31:0] expd;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } res_t;

    vec_t vecs [10];
    res_t exp_q [$];
    int   passed = 0;
    int   total  = 0;
    int   npop   = 0;
    bit   last_acc;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] m);
        logic [63:0] dd;
        logic signed [31:0] sd;
        case (m)
            2'd0: return d << sh;
            2'd1: return d >> sh;
            2'd2: begin
                sd = $signed(d) >>> sh;
                return sd;
            end
            default: begin
                dd = {d, d} >> sh;
                return dd[31:0];
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    // One cycle of handshake traffic scored against the queue model.
    task automatic step();
        res_t r;
        @(negedge clk);
        check("inflight_vs_model", 32'(inflight), 32'(exp_q.size()));
        check("inflight_cap", 32'(inflight <= 6'd5), 32'd1);
        check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            npop++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                check("out_data", out_data, r.d);
                check("out_tag", 32'(out_tag), 32'(r.t));
            end
        end
        if (last_acc) begin
            r.d = ref_shift(in_data, int'(in_shamt), in_mode);
            r.t = in_tag;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random(input logic v);
        in_valid = v;
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_mode  = 2'($urandom_range(0, 3));
        in_tag   = 5'($urandom_range(0, 31));
    endtask

    task automatic run_single(input string name, input logic [31:0] d, input logic [4:0] sh,
                              input logic [1:0] m, input logic [4:0] tg, input logic [31:0] expv);
        int cyc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = sh;
        in_mode   = m;
        in_tag    = tg;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        cyc = 1;
        @(negedge clk);
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(cyc), 32'd5);
        check({name, "_data"}, out_data, expv);
        check({name, "_tag"}, 32'(out_tag), 32'(tg));
        @(posedge clk);
        #1;
        check({name, "_drained"}, 32'(inflight), 32'd0);
    endtask

    initial begin
        int i;
        int cyc;
        logic [4:0] t0;

        vecs[0] = '{32'h8000_0000, 5'd16, 2'd2, 32'hFFFF_8000};
        vecs[1] = '{32'h8000_0000, 5'd16, 2'd1, 32'h0000_8000};
        vecs[2] = '{32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000};
        vecs[3] = '{32'h0000_0001, 5'd1,  2'd3, 32'h8000_0000};
        vecs[4] = '{32'h1234_5678, 5'd8,  2'd3, 32'h7812_3456};
        vecs[5] = '{32'hA5A5_1234, 5'd0,  2'd0, 32'hA5A5_1234};
        vecs[6] = '{32'hA5A5_1234, 5'd0,  2'd1, 32'hA5A5_1234};
        vecs[7] = '{32'hA5A5_1234, 5'd0,  2'd2, 32'hA5A5_1234};
        vecs[8] = '{32'hA5A5_1234, 5'd0,  2'd3, 32'hA5A5_1234};
        vecs[9] = '{32'h7000_0000, 5'd4,  2'd2, 32'h0700_0000};

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        for (int v = 0; v < 10; v++)
            run_single($sformatf("vec%0d", v), vecs[v].data, vecs[v].shamt, vecs[v].mode,
                       5'(v + 3), vecs[v].expd);

        // 8 back-to-back ops against a blocked consumer
        exp_q.delete();
        npop = 0;
        i = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive_random(1'b1);
            in_tag = 5'(i + 1);
            step();
            if (last_acc) i++;
        end
        check("stall_accepted", 32'(i), 32'd5);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_inflight", 32'(inflight), 32'd5);
        out_ready = 1'b1;
        cyc = 0;
        while ((i < 8 || exp_q.size() != 0) && cyc < 60) begin
            drive_random(i < 8);
            in_tag = 5'(i + 1);
            step();
            if (last_acc) i++;
            cyc++;
        end
        check("stall_all_out", 32'(npop), 32'd8);

        // Random traffic
        i = 0;
        cyc = 0;
        while (i < 1000 && cyc < 20000) begin
            out_ready = ($urandom_range(0, 2) != 0);
            drive_random($urandom_range(0, 3) != 0);
            step();
            if (last_acc) i++;
            cyc++;
        end
        check("rand_sent", 32'(i), 32'd1000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            step();
            cyc++;
        end
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Flush with 3 ops in flight and a fresh op offered
        for (int c = 0; c < 3; c++) begin
            drive_random(1'b1);
            step();
        end
        drive_random(1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_inflight", 32'(inflight), 32'd0);
        for (int c = 0; c < 10; c++) step();
        run_single("post_flush", 32'h0000_00F0, 5'd4, 2'd1, 5'd9, 32'h0000_000F);

        // Async reset mid-stream with a result parked at the output
        out_ready = 1'b0;
        cyc = 0;
        t0 = 5'h1F;
        while (!out_valid && cyc < 20) begin
            drive_random(1'b1);
            in_data = 32'hFFFF_FFFF; in_shamt = 5'd0; in_mode = 2'd0; in_tag = t0;
            step();
            cyc++;
        end
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", out_data, 32'd0);
        check("async_rst_out_tag", 32'(out_tag), 32'd0);
        check("async_rst_inflight", 32'(inflight), 32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_single("post_rst", 32'hF000_0000, 5'd4, 2'd2, 5'd7, 32'hFF00_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
